// File: rtl/sub_64_serial.sv
// Byte-serial 64-bit subtractor: one byte of A + ~B + carry per cycle, LSB first.
// Optional macro SUB64_SATURATE_EN clamps DIFF_OUT to the signed limits on overflow.
module sub_64_serial (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [63:0] MINUEND,
    input  logic [63:0] SUBTRAHEND,
    output logic        BUSY,
    output logic        DONE,
    output logic [63:0] DIFF_OUT,
    output logic        BO,
    output logic        OVO,
    output logic        ZO
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [63:0] a_q, b_q;
    logic [63:0] acc_q, acc_d;
    logic [2:0]  cnt_q;
    logic        borrow_q;
    logic [8:0]  byte_sum;
    logic        raw_ovf;
    logic [63:0] final_diff;

    always_ff @(posedge CLK) begin
        if (RESET) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (START) state_d = S_RUN;
            S_RUN:   if (cnt_q == 3'd7) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        BUSY = (state_q != S_IDLE);
        DONE = (state_q == S_DONE);
    end

    // Carry into the byte adder is the inverse of the stored borrow, so a cleared borrow gives carry-in 1.
    always_comb begin
        byte_sum = {1'b0, a_q[{cnt_q, 3'b000} +: 8]} + {1'b0, ~b_q[{cnt_q, 3'b000} +: 8]}
                 + {8'b0, ~borrow_q};
        acc_d = acc_q;
        acc_d[{cnt_q, 3'b000} +: 8] = byte_sum[7:0];
        raw_ovf = (a_q[63] != b_q[63]) && (acc_d[63] != a_q[63]);
`ifdef SUB64_SATURATE_EN
        if (raw_ovf) final_diff = a_q[63] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
        else         final_diff = acc_d;
`else
        final_diff = acc_d;
`endif
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            DIFF_OUT <= '0;
            BO       <= 1'b0;
            OVO      <= 1'b0;
            ZO       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (START) begin
                    a_q      <= MINUEND;
                    b_q      <= SUBTRAHEND;
                    cnt_q    <= '0;
                    borrow_q <= 1'b0;
                end
                S_RUN: begin
                    acc_q    <= acc_d;
                    borrow_q <= ~byte_sum[8];
                    cnt_q    <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        DIFF_OUT <= final_diff;
                        BO       <= ~byte_sum[8];
                        OVO      <= raw_ovf;
                        ZO       <= (final_diff == 64'd0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sub_64_serial.sv
// Scoreboard bench for sub_64_serial: a cycle-level acceptance model predicts results and DONE timing.
module tb_sub_64_serial;

    logic        CLK = 1'b0;
    logic        RESET, START;
    logic [63:0] MINUEND, SUBTRAHEND;
    logic        BUSY, DONE, BO, OVO, ZO;
    logic [63:0] DIFF_OUT;

    sub_64_serial dut (
        .CLK(CLK), .RESET(RESET), .START(START),
        .MINUEND(MINUEND), .SUBTRAHEND(SUBTRAHEND),
        .BUSY(BUSY), .DONE(DONE), .DIFF_OUT(DIFF_OUT),
        .BO(BO), .OVO(OVO), .ZO(ZO)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [63:0] diff;
        logic        bo, ovo, zo;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0, fails = 0;
    int          cyc = 0;
    int          free_cnt = 0;
    bit          mon_en = 0;
    logic [63:0] last_diff = '0;
    logic        last_bo = 0, last_ovo = 0, last_zo = 0;

    function automatic exp_t ref_model(logic [63:0] a, logic [63:0] b, int due);
        exp_t e;
        e.diff = a - b;
        e.bo   = (a < b);
        e.ovo  = (a[63] != b[63]) && (e.diff[63] != a[63]);
`ifdef SUB64_SATURATE_EN
        if (e.ovo) e.diff = a[63] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
`endif
        e.zo  = (e.diff == 64'd0);
        e.due = due;
        return e;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: one acceptance, then the block is unavailable for the next 9 edges.
    always @(posedge CLK) begin
        cyc++;
        if (RESET) begin
            sb.delete();
            free_cnt  = 0;
            last_diff = '0;
            {last_bo, last_ovo, last_zo} = 3'b000;
        end else if (free_cnt == 0 && START === 1'b1) begin
            sb.push_back(ref_model(MINUEND, SUBTRAHEND, cyc + 8));
            free_cnt = 9;
        end else if (free_cnt > 0) begin
            free_cnt--;
        end
    end

    always @(negedge CLK) begin
        if (mon_en) begin
            chk("busy", {63'd0, BUSY}, {63'd0, free_cnt != 0});
            chk("done", {63'd0, DONE}, {63'd0, free_cnt == 1});
            if (DONE === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("done_unexpected", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(e.due));
                    last_diff = e.diff;
                    {last_bo, last_ovo, last_zo} = {e.bo, e.ovo, e.zo};
                end
            end
            chk("diff", DIFF_OUT, last_diff);
            chk("bo",   {63'd0, BO},  {63'd0, last_bo});
            chk("ovo",  {63'd0, OVO}, {63'd0, last_ovo});
            chk("zo",   {63'd0, ZO},  {63'd0, last_zo});
        end
    end

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Present START for one edge, then scramble operands; next op lands on the earliest acceptance edge.
    task automatic op(logic [63:0] a, logic [63:0] b);
        @(negedge CLK);
        START = 1'b1; MINUEND = a; SUBTRAHEND = b;
        @(negedge CLK);
        START = 1'b0; MINUEND = rnd64(); SUBTRAHEND = rnd64();
        repeat (8) @(negedge CLK);
    endtask

    logic [63:0] ra, rb;

    initial begin
        RESET = 1'b1; START = 1'b0; MINUEND = '0; SUBTRAHEND = '0;
        repeat (3) @(negedge CLK);
        mon_en = 1;
        START = 1'b1;
        @(negedge CLK);
        RESET = 1'b0; START = 1'b0;

        op(64'd5, 64'd3);
        op(64'd0, 64'd1);
        op(64'h8000_0000_0000_0000, 64'd1);
        op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0);
        op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        op(64'd0, 64'h8000_0000_0000_0000);
        op(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        op(64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF);

        for (int i = 0; i < 24; i++) begin
            ra = rnd64();
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra ^ (64'd1 << $urandom_range(0, 63));
                default: rb = rnd64();
            endcase
            op(ra, rb);
        end

        // START held high, operands changing every cycle: one result per 10 cycles.
        @(negedge CLK);
        START = 1'b1;
        for (int i = 0; i < 45; i++) begin
            MINUEND = rnd64(); SUBTRAHEND = rnd64();
            @(negedge CLK);
        end
        START = 1'b0;
        repeat (10) @(negedge CLK);

        // Reset mid-RUN discards the op; restart on the first edge after reset.
        START = 1'b1; MINUEND = 64'd100; SUBTRAHEND = 64'd7;
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0; START = 1'b1; MINUEND = 64'd9; SUBTRAHEND = 64'd10;
        @(negedge CLK);
        START = 1'b0; MINUEND = rnd64(); SUBTRAHEND = rnd64();
        repeat (12) @(negedge CLK);

        chk("drain", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
